// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter.
//   shift_op_e    : operation codes on op_i (codes 5..7 are reserved, pass-through)
//   shift_state_e : control FSM states of shift_iter
//   is_shift_op() : true for the five defined operations
package shift_pkg;

  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shifts or rotates data_i by amt_i bits.
// Purely combinational.
//   op_i   : operation (shift_op_e); reserved codes pass data_i through
//   data_i : working value
//   amt_i  : bits to move this step, 0..STEP
//   sign_i : fill bit for SRA (the operand's original sign)
//   data_o : stepped value
module shift_step
  import shift_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int STEP  = 4,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             sign_i,
  output logic [XLEN-1:0]  data_o
);

  // Mask of the top amt_i bits, used to inject the sign on arithmetic shifts.
  logic [XLEN-1:0] hi_mask;
  assign hi_mask = ~({XLEN{1'b1}} >> amt_i);

  // NOTE: data_o gets a default before the case so every path assigns it
  // and no latch is inferred for the reserved opcodes.
  always_comb begin
    data_o = data_i;
    case (op_i)
      SH_SLL:  data_o = data_i << amt_i;
      SH_SRL:  data_o = data_i >> amt_i;
      SH_SRA:  data_o = (data_i >> amt_i) | (hi_mask & {XLEN{sign_i}});
      // A shift by XLEN yields zero, so amt_i == 0 leaves data unchanged.
      SH_ROL:  data_o = (data_i << amt_i) | (data_i >> (XLEN - int'(amt_i)));
      SH_ROR:  data_o = (data_i >> amt_i) | (data_i << (XLEN - int'(amt_i)));
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle iterative shifter with valid/ready handshakes and flush.
// Moves up to STEP bits per cycle until the requested amount is consumed.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_i                 : abort in-flight/pending operation
//   in_valid_i/in_ready_o   : request handshake (op_i, op1_i, op2_i)
//   out_valid_o/out_ready_i : result handshake (res_o)
//   busy_o                  : unit not idle
module shift_iter
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int AMT_W   = $clog2(STEP + 1);

  shift_state_e       state_q, state_d;
  logic [2:0]         op_q,    op_d;
  logic [XLEN-1:0]    data_q,  data_d;
  logic [SHAMT_W-1:0] rem_q,   rem_d;
  logic               sign_q,  sign_d;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W-1:0] rem_after;
  logic [AMT_W-1:0]   amt;
  logic [XLEN-1:0]    step_data;

  // Shift amounts are modulo XLEN; the upper operand bits are deliberately dropped.
  logic unused_op2_hi;
  assign unused_op2_hi = ^op2_i[XLEN-1:SHAMT_W];
  assign shamt         = op2_i[SHAMT_W-1:0];

  // A new request may land in the same cycle the previous result is taken.
  assign in_ready_o  = !rst_i && !flush_i &&
                       (state_q == IDLE || (state_q == DONE && out_ready_i));
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign res_o       = data_q;

  // Step size is min(STEP, remaining); the comparison is done at int width
  // because STEP may exceed the range of rem_q.
  always_comb begin
    if (int'(rem_q) >= STEP) amt = AMT_W'(STEP);
    else                     amt = AMT_W'(rem_q);
  end

  assign rem_after = rem_q - SHAMT_W'(amt);

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .op_i   (op_q),
    .data_i (data_q),
    .amt_i  (amt),
    .sign_i (sign_q),
    .data_o (step_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    if (flush_i) begin
      // Result register is left untouched so res_o keeps its last value.
      state_d = IDLE;
      rem_d   = '0;
    end else if (accept) begin
      op_d   = op_i;
      data_d = op1_i;
      sign_d = op1_i[XLEN-1];
      // Zero shifts and reserved codes finish immediately with res = op1.
      if (shamt != '0 && is_shift_op(op_i)) begin
        rem_d   = shamt;
        state_d = SHIFT;
      end else begin
        rem_d   = '0;
        state_d = DONE;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          data_d = step_data;
          rem_d  = rem_after;
          if (rem_after == '0) state_d = DONE;
        end
        DONE:    if (out_ready_i) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      data_q  <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
    end
  end

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter (XLEN=32, STEP=4): directed cases,
// backpressure, flush, reset, then randomized traffic against a reference model.
module tb_shift_iter;

  localparam int XLEN = 32;
  localparam int STEP = 4;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]      op;
  logic [XLEN-1:0] op1, op2, res;

  always #5 clk = ~clk;

  shift_iter #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .op1_i       (op1),
    .op2_i       (op2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .busy_o      (busy)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
    int              acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rnd_on = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: whole-operation result straight from the operation definitions.
  function automatic logic [XLEN-1:0] model_res(input logic [2:0] o, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    int s = int'(b) % XLEN;
    if (s < 0) s += XLEN;
    case (o)
      3'd0: return a << s;
      3'd1: return a >> s;
      3'd2: return $signed(a) >>> s;
      3'd3: return (s == 0) ? a : ((a << s) | (a >> (XLEN - s)));
      3'd4: return (s == 0) ? a : ((a >> s) | (a << (XLEN - s)));
      default: return a;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [XLEN-1:0] b);
    int s = int'(b[4:0]);
    if (o > 3'd4 || s == 0) return 1;
    return 1 + (s + STEP - 1) / STEP;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents one request starting now (just after a rising edge) and returns
  // just after the accepting edge. ov_at_acc reports whether a result was
  // being offered in the accepting cycle.
  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit push, output bit ov_at_acc);
    int   w = 0;
    exp_t e;
    op = o; op1 = a; op2 = b; in_valid = 1'b1;
    ov_at_acc = 1'b0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", w);
    end else begin
      ov_at_acc = out_valid;
      if (push) begin
        e.res = model_res(o, a, b);
        e.lat = model_lat(o, b);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
    sync();
    in_valid = 1'b0;
    op = 3'($urandom); op1 = $urandom; op2 = $urandom;
  endtask

  // Waits (bounded) until a result is offered; ends on that falling edge.
  task automatic wait_valid(input bit chk_busy);
    int w = 0;
    @(negedge clk);
    while (!out_valid && w < 100) begin
      if (chk_busy) check("busy_during_op", busy, 1);
      w++;
      @(negedge clk);
    end
    if (!out_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL valid_timeout: out_valid stayed 0 for %0d cycles", w);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake and checks value,
  // latency and that res_o holds while a result waits for the consumer.
  logic            prev_valid = 1'b0;
  logic            prev_hs = 1'b0;
  logic [XLEN-1:0] prev_res = '0;
  int              start_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && (!prev_valid || prev_hs)) start_cyc = cyc;
      if (out_valid && prev_valid && !prev_hs) check("hold_res", res, prev_res);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", res);
        end else begin
          e = sb.pop_front();
          check("result", res, e.res);
          check("latency", 64'(start_cyc - e.acc), 64'(e.lat));
        end
      end
    end
    prev_valid = out_valid;
    prev_hs    = out_valid && out_ready;
    prev_res   = res;
  end

  initial begin
    bit              ov;
    bit              seen;
    logic [XLEN-1:0] saved;
    int              w;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; op1 = '0; op2 = '0;

    // Reset state
    @(negedge clk);
    check("rst_res", res, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    sync();
    rst = 1'b0;

    // Long shift, busy held throughout
    issue(3'd0, 32'h0000_0001, 32'd31, 1, ov);
    wait_valid(1);
    sync();

    // Modulo shift amount, arithmetic vs logical
    issue(3'd2, 32'h8000_0000, 32'h24, 1, ov); wait_valid(0); sync();
    issue(3'd1, 32'h8000_0000, 32'h24, 1, ov); wait_valid(0); sync();
    // Rotates
    issue(3'd4, 32'h1234_5678, 32'd8, 1, ov); wait_valid(0); sync();
    issue(3'd3, 32'h1234_5678, 32'd4, 1, ov); wait_valid(0); sync();
    // Zero shift and reserved opcode
    issue(3'd1, 32'hDEAD_BEEF, 32'd0, 1, ov); wait_valid(0); sync();
    issue(3'd7, 32'hCAFE_F00D, 32'd9, 1, ov); wait_valid(0); sync();

    // Backpressure then zero-bubble back-to-back
    out_ready = 1'b0;
    issue(3'd4, 32'h1234_5678, 32'd8, 1, ov);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
    end
    sync();
    out_ready = 1'b1;
    issue(3'd0, 32'h0000_0001, 32'd4, 1, ov);
    check("b2b_both_handshakes", ov, 1);
    wait_valid(0);
    sync();

    // Flush during SHIFT
    issue(3'd0, 32'h0000_0003, 32'd20, 0, ov);
    sync();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready_gated", in_ready, 0);
    saved = res;
    sync();
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready_after", in_ready, 1);
    check("flush_busy_after", busy, 0);
    check("flush_res_kept", res, saved);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush_no_valid", seen, 0);
    sync();

    // Flush with a request in IDLE: not accepted
    in_valid = 1'b1; op = 3'd0; op1 = 32'h5; op2 = 32'd3; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_in_ready", in_ready, 0);
    sync();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", busy, 0);
    check("flush_idle_out_valid", out_valid, 0);
    sync();

    // Reset mid-SHIFT
    issue(3'd0, 32'h0000_0001, 32'd28, 0, ov);
    sync();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    sync();
    @(negedge clk);
    check("rst_mid_res", res, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    sync();
    rst = 1'b0;

    // Randomized traffic with random consumer backpressure
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          if (rnd_on) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, 1, ov);
      repeat ($urandom_range(0, 2)) sync();
    end
    rnd_on = 0;
    sync();
    sync();
    out_ready = 1'b1;
    w = 0;
    while (sb.size() > 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
